// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Keeps the word-addressed fetch PC and issues in-order reads to instruction
// memory. Returned words are buffered with their PC for decode. A redirect
// from jump_branch flushes the buffer, and the responses that are still in
// flight at that point are counted so they can be dropped when they return.
//
// Handshake semantics (both sides use the same rule): a transfer happens
// in a cycle where the producer's valid (imem_req / inst_valid) and the
// consumer's ready (imem_gnt / dec_ready) are both 1. A producer holds its
// valid and payload steady until the transfer happens; the one exception
// is a redirect, which withdraws both imem_req and inst_valid.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        jb_enable,
  input  logic [31:0] jb_target_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dec_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;    // requests granted, not yet returned
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;  // in-flight responses known stale
  logic [CW-1:0] count_q, count_d;        // buffered entries
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q   [FIFO_DEPTH];
  logic [31:0]   inst_mem_q [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic          buf_nonempty;
  logic          grant;
  logic          push;
  logic          pop;

  // Credits cover both buffered and in-flight entries, so every response
  // always has a free slot waiting for it.
  assign credit_used  = {1'b0, out_cnt_q} + {1'b0, count_q};
  assign buf_nonempty = (count_q != '0);

  assign imem_req   = reset_n && !jb_enable && (credit_used < {1'b0, DEPTH_C});
  assign imem_addr  = fetch_pc_q;
  assign grant      = imem_req && imem_gnt;

  // The head is hidden during a redirect so decode never takes a wrong-path word.
  assign inst_valid = buf_nonempty && !jb_enable;
  assign inst       = buf_nonempty ? inst_mem_q[rd_ptr_q] : 32'h0;
  assign inst_pc    = buf_nonempty ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign pop        = inst_valid && dec_ready;

  // A response is kept only outside a redirect cycle and when nothing stale is pending.
  assign push       = imem_rvalid && !jb_enable && (drop_cnt_q == '0);

  // Next-state for PCs, counters and buffer pointers; a redirect overrides all.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_cnt_d  = out_cnt_q - CW'(imem_rvalid) + CW'(grant);
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd1;
    end
    if (push) begin
      resp_pc_d = resp_pc_q + 32'd1;
    end
    if (imem_rvalid && !jb_enable && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    if (jb_enable) begin
      // No grant is possible here, so everything still in flight after this
      // cycle's response is stale.
      fetch_pc_d = jb_target_pc;
      resp_pc_d  = jb_target_pc;
      drop_cnt_d = out_cnt_q - CW'(imem_rvalid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // A push into a full buffer means the credit accounting is broken.
  no_overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && (count_q == DEPTH_C)));

endmodule
